// File: rtl/pc_call_stack_counter_pkg.sv
// Shared definitions for the Nibbler program counter: one-hot op codes and
// the width helper used to size the return-stack pointer.
package nibbler_pc_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_HOLD = 5'b00001;
    localparam logic [OP_W-1:0] OP_INC  = 5'b00010;
    localparam logic [OP_W-1:0] OP_LOAD = 5'b00100;
    localparam logic [OP_W-1:0] OP_CALL = 5'b01000;
    localparam logic [OP_W-1:0] OP_RET  = 5'b10000;

    // Bits needed to hold values 0 .. value-1; callers pass DEPTH+1 so that
    // a completely full stack still fits in the pointer.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_call_stack_counter_if.sv
// Decoder-facing bundle of the program counter: op strobes and jump target in,
// PC value and stack/wrap status out.
interface pc_call_stack_counter_if
    import nibbler_pc_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    localparam int SPW = clog2(DEPTH + 1);

    logic             enable;
    logic             load;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] Count;
    logic             wrap;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;
    logic [SPW-1:0]   sp;

    modport master (
        output enable, load, call, ret, DATA_IN,
        input  Count, wrap, stack_full, stack_empty, stack_err, sp
    );

    modport slave (
        input  enable, load, call, ret, DATA_IN,
        output Count, wrap, stack_full, stack_empty, stack_err, sp
    );

endinterface

// File: rtl/pc_call_stack_counter_lifo_stack.sv
// Return-address LIFO: refuses a push when full or a pop when empty and
// flags the refused attempt on err in the same cycle.
module lifo_stack
    import nibbler_pc_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int SPW = clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [SPW-1:0]   sp,
    output logic             err
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign err   = (push && full) || (pop && empty);

    // Top-of-stack read; a mux over valid entries avoids ever indexing past DEPTH.
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) begin
                pop_data = mem[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp == SPW'(i)) begin
                    mem[i] <= push_data;
                end
            end
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/pc_call_stack_counter.sv
// Nibbler program counter: increment, jump, call and return with a bounded
// return stack, plus one-cycle wrap and stack-fault pulses.
module pc_call_stack_counter
    import nibbler_pc_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input logic                    CLK,
    input logic                    reset,
    pc_call_stack_counter_if.slave bus
);

    localparam int SPW = clog2(DEPTH + 1);

    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             stack_err_q;
    logic [WIDTH-1:0] pop_data;
    logic             full;
    logic             empty;
    logic             lifo_err;
    logic [SPW-1:0]   sp;

    // Only the highest-priority strobe survives; the rest are silently dropped.
    always_comb begin
        op = OP_HOLD;
        if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.call) begin
            op = OP_CALL;
        end else if (bus.ret) begin
            op = OP_RET;
        end else if (bus.enable) begin
            op = OP_INC;
        end
    end

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .CLK       (CLK),
        .reset     (reset),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (count_q + WIDTH'(1)),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .sp        (sp),
        .err       (lifo_err)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q     <= '0;
            wrap_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            wrap_q      <= 1'b0;
            stack_err_q <= lifo_err;
            case (op)
                OP_LOAD: count_q <= bus.DATA_IN;
                OP_CALL: if (!full) count_q <= bus.DATA_IN;
                OP_RET:  if (!empty) count_q <= pop_data;
                OP_INC: begin
                    count_q <= count_q + WIDTH'(1);
                    wrap_q  <= &count_q;
                end
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.Count       = count_q;
    assign bus.wrap        = wrap_q;
    assign bus.stack_err   = stack_err_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.sp          = sp;

endmodule
